// File: rtl/div_issue_ctrl_if.sv
// Request/divider handshake bundle for div_issue_ctrl.
// master = the issue controller, slave = pipeline plus divider side.
interface div_issue_ctrl_if;
   logic        req_valid_i;
   logic        req_signed_i;
   logic [31:0] req_op1_i;
   logic [31:0] req_op2_i;
   logic        flush_i;
   logic        stall_i;
   logic [63:0] div_result_i;
   logic        div_ready_i;
   logic        div_start_o;
   logic        div_annul_o;
   logic        div_signed_o;
   logic [31:0] div_op1_o;
   logic [31:0] div_op2_o;
   logic        stallreq_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        whilo_o;

   modport master (
      input  req_valid_i, req_signed_i, req_op1_i, req_op2_i,
      input  flush_i, stall_i, div_result_i, div_ready_i,
      output div_start_o, div_annul_o, div_signed_o,
      output div_op1_o, div_op2_o, stallreq_o,
      output hi_o, lo_o, whilo_o
   );

   modport slave (
      output req_valid_i, req_signed_i, req_op1_i, req_op2_i,
      output flush_i, stall_i, div_result_i, div_ready_i,
      input  div_start_o, div_annul_o, div_signed_o,
      input  div_op1_o, div_op2_o, stallreq_o,
      input  hi_o, lo_o, whilo_o
   );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle divider (HI/LO write).
// Optional DIV_ZERO_FASTPATH_EN: divide-by-zero completes without the divider.
module div_issue_ctrl (
   input  logic              clk,
   input  logic              rst,
   div_issue_ctrl_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE,
      ABORT
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        start_q, start_d;
   logic        annul_q, annul_d;
   logic        sgn_q, sgn_d;
   logic [31:0] op1_q, op1_d;
   logic [31:0] op2_q, op2_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        zero_fast;
   logic        take;

`ifdef DIV_ZERO_FASTPATH_EN
   assign zero_fast = (bus.req_op2_i == 32'd0);
`else
   assign zero_fast = 1'b0;
`endif

   assign take = bus.req_valid_i & ~bus.flush_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         start_q <= 1'b0;
         annul_q <= 1'b0;
         sgn_q   <= 1'b0;
         op1_q   <= 32'd0;
         op2_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         annul_q <= annul_d;
         sgn_q   <= sgn_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = 2'd0;
      start_d = 1'b0;
      annul_d = 1'b0;
      sgn_d   = sgn_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE: begin
            if (take && zero_fast) begin
               hi_d    = 32'd0;
               lo_d    = 32'd0;
               state_d = DONE;
            end else if (take) begin
               sgn_d   = bus.req_signed_i;
               op1_d   = bus.req_op1_i;
               op2_d   = bus.req_op2_i;
               start_d = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // flush wins over a result arriving in the same cycle
            if (bus.flush_i) begin
               annul_d = 1'b1;
               state_d = ABORT;
            end else if (bus.div_ready_i) begin
               hi_d    = bus.div_result_i[63:32];
               lo_d    = bus.div_result_i[31:0];
               state_d = DONE;
            end else begin
               start_d = 1'b1;
            end
         end
         DONE: begin
            if (bus.stall_i && !bus.flush_i) begin
               state_d = DONE;
            end else begin
               state_d = IDLE;
            end
         end
         ABORT: begin
            // three cycles let the divider drain back to Free
            if (cnt_q == 2'd2) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.div_start_o  = start_q;
   assign bus.div_annul_o  = annul_q;
   assign bus.div_signed_o = sgn_q;
   assign bus.div_op1_o    = op1_q;
   assign bus.div_op2_o    = op2_q;
   assign bus.hi_o         = hi_q;
   assign bus.lo_o         = lo_q;

   assign bus.stallreq_o = ((state_q == IDLE) & take)
                         | (state_q == BUSY)
                         | ((state_q == ABORT) & bus.req_valid_i);

   assign bus.whilo_o = (state_q == DONE) & ~bus.flush_i;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized bench for div_issue_ctrl with a behavioural divider model.
// Define DIV_ZERO_FASTPATH_EN here as well to check the fastpath build.
module tb_div_issue_ctrl;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;
   int   exp_starts;
   int   n_starts;
   int   dcnt;
   logic start_prev;
   logic [63:0] noise;

   div_issue_ctrl_if bus ();

   div_issue_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] div_ref(input bit sg,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [31:0] q, r;
      if (b == 32'd0) return 64'd0;
      if (sg) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   function automatic bit fastpath(input logic [31:0] b);
`ifdef DIV_ZERO_FASTPATH_EN
      return (b == 32'd0);
`else
      return 1'b0;
`endif
   endfunction

   // divider: ready 35 cycles after start (3 for a zero divisor)
   always @(posedge clk) begin
      noise <= {$urandom, $urandom};
      if (rst || !bus.div_start_o) dcnt <= 0;
      else dcnt <= dcnt + 1;
      start_prev <= rst ? 1'b0 : bus.div_start_o;
      if (!rst && bus.div_start_o && !start_prev) n_starts <= n_starts + 1;
   end

   assign bus.div_ready_i = bus.div_start_o &&
      (dcnt >= ((bus.div_op2_o == 32'd0) ? 3 : 35));
   assign bus.div_result_i = bus.div_ready_i ?
      div_ref(bus.div_signed_o, bus.div_op1_o, bus.div_op2_o) : noise;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_start"}, bus.div_start_o, 0);
      check({tag, "_annul"}, bus.div_annul_o, 0);
      check({tag, "_signed"}, bus.div_signed_o, 0);
      check({tag, "_op1"}, bus.div_op1_o, 0);
      check({tag, "_op2"}, bus.div_op2_o, 0);
      check({tag, "_hi"}, bus.hi_o, 0);
      check({tag, "_lo"}, bus.lo_o, 0);
      check({tag, "_stallreq"}, bus.stallreq_o, 0);
      check({tag, "_whilo"}, bus.whilo_o, 0);
   endtask

   // one instruction from its first EX cycle (k=0) until it leaves EX;
   // fl>0 flushes at k=fl, st stalls DONE, dfl flushes in DONE
   task automatic run_div(input bit sg, input logic [31:0] a,
                          input logic [31:0] b, input int fl,
                          input int st, input bit dfl);
      logic [63:0] r;
      bit fast;
      int d, last;
      r    = div_ref(sg, a, b);
      fast = fastpath(b);
      d    = fast ? 1 : ((b == 32'd0) ? 5 : 37);
      last = (fl > 0) ? fl + 3 : d + st;
      if (!fast) exp_starts++;
      for (int k = 0; k <= last; k++) begin
         bus.req_valid_i  = (fl > 0) ? (k <= fl || k >= fl + 2) : 1'b1;
         bus.req_signed_i = sg;
         bus.req_op1_i    = a;
         bus.req_op2_i    = b;
         bus.flush_i      = (fl > 0 && k == fl) || (dfl && k == d);
         bus.stall_i      = (fl == 0) && (k >= d) && (k < d + st);
         @(negedge clk);
         if (fl > 0) begin
            check("abort_stallreq", bus.stallreq_o, k != fl + 1);
            check("abort_start", bus.div_start_o, k >= 1 && k <= fl);
            check("abort_annul", bus.div_annul_o, k == fl + 1);
            check("abort_whilo", bus.whilo_o, 0);
         end else begin
            check("stallreq", bus.stallreq_o, k < d);
            check("start", bus.div_start_o, !fast && k >= 1 && k < d);
            check("annul", bus.div_annul_o, 0);
            check("whilo", bus.whilo_o, k >= d && !dfl);
            if (k >= d) begin
               check("hi", bus.hi_o, r[63:32]);
               check("lo", bus.lo_o, r[31:0]);
            end
         end
         if (k == 1 && !fast) begin
            check("div_signed", bus.div_signed_o, sg);
            check("div_op1", bus.div_op1_o, a);
            check("div_op2", bus.div_op2_o, b);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_reset_mid(input logic [31:0] a, input logic [31:0] b);
      exp_starts++;
      for (int k = 0; k <= 20; k++) begin
         bus.req_valid_i  = 1'b1;
         bus.req_signed_i = 1'b1;
         bus.req_op1_i    = a;
         bus.req_op2_i    = b;
         bus.flush_i      = 1'b0;
         bus.stall_i      = 1'b0;
         rst              = (k == 20);
         @(negedge clk);
         if (k == 20) check("rst_busy_stallreq", bus.stallreq_o, 1);
         @(posedge clk);
         #1;
      end
      rst             = 1'b0;
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      check_zero_outputs("rst_mid");
      @(posedge clk);
      #1;
   endtask

   task automatic run_idle_flush();
      bus.req_valid_i  = 1'b1;
      bus.req_signed_i = 1'b0;
      bus.req_op1_i    = 32'd77;
      bus.req_op2_i    = 32'd5;
      bus.flush_i      = 1'b1;
      bus.stall_i      = 1'b0;
      @(negedge clk);
      check("iflush_stallreq", bus.stallreq_o, 0);
      check("iflush_whilo", bus.whilo_o, 0);
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      bus.flush_i     = 1'b0;
      @(negedge clk);
      check("iflush_start", bus.div_start_o, 0);
      check("iflush_stallreq2", bus.stallreq_o, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk            = 0;
      n_err            = 0;
      exp_starts       = 0;
      n_starts         = 0;
      rst              = 1'b1;
      bus.req_valid_i  = 1'b0;
      bus.req_signed_i = 1'b0;
      bus.req_op1_i    = 32'd0;
      bus.req_op2_i    = 32'd0;
      bus.flush_i      = 1'b0;
      bus.stall_i      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_div(1'b0, 32'd100, 32'd7, 0, 0, 1'b0);
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0, 0, 1'b0);
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, 0, 0, 1'b0);
      run_div(1'b0, 32'd5, 32'd0, 0, 0, 1'b0);
      run_div(1'b0, 32'd1000, 32'd13, 10, 0, 1'b0);
      run_div(1'b0, 32'd9, 32'd3, 0, 0, 1'b0);
      run_div(1'b0, 32'd12345, 32'd77, 0, 3, 1'b0);
      run_reset_mid(32'd500, 32'd9);
      run_div(1'b0, 32'd9, 32'd3, 0, 0, 1'b0);
      run_idle_flush();
      run_div(1'b1, 32'hFFFFFF9C, 32'd7, 0, 0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         bit sg;
         logic [31:0] a, b;
         int m, fl, st, dl;
         sg = 1'($urandom);
         a  = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         m  = $urandom_range(0, 3);
         dl = (b == 32'd0) ? 5 : 37;
         if (m == 2 && fastpath(b)) m = 0;
         fl = (m == 2) ? $urandom_range(1, dl - 1) : 0;
         st = (m == 1) ? $urandom_range(1, 4) : 0;
         run_div(sg, a, b, fl, st, m == 3);
      end

      bus.req_valid_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("start_count", n_starts, exp_starts);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

EX-stage initiator for the multi-cycle divider. It accepts a DIV/DIVU request from the EX stage and drives the divider's start/annul/operand handshake. It holds the pipeline with a stall request until the 64-bit quotient/remainder returns, then presents HI/LO write data to EX/MEM. It also handles flush (annul) and downstream stalls so that every instruction starts exactly one division and produces at most one HI/LO write.

## Interface
Parameters:
- none (width fixed at 32-bit operands, 64-bit result)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  DIV/DIVU instruction present in EX
- req_signed_i  in  1  1 = DIV (signed), 0 = DIVU
- req_op1_i  in  32  dividend (rs)
- req_op2_i  in  32  divisor (rt)
- flush_i  in  1  pipeline flush; kill current division
- stall_i  in  1  downstream stall; EX instruction frozen this cycle
- div_result_i  in  64  from divider, {remainder, quotient}
- div_ready_i  in  1  divider result valid
- div_start_o  out  1  start to divider (registered)
- div_annul_o  out  1  annul to divider (registered)
- div_signed_o  out  1  signed select to divider (registered)
- div_op1_o  out  32  latched dividend to divider
- div_op2_o  out  32  latched divisor to divider
- stallreq_o  out  1  stall request to pipeline control (combinational)
- hi_o  out  32  remainder for HI
- lo_o  out  32  quotient for LO
- whilo_o  out  1  HI/LO write enable (combinational)

## Operation
- States: IDLE, BUSY, DONE, ABORT. Reset: IDLE; all registered outputs 0; hi_o = lo_o = 0.
- IDLE:
  - On req_valid_i & !flush_i: latch req_signed/op1/op2 into div_* outputs, set div_start_o = 1, go BUSY.
  - On req_valid_i & flush_i: request ignored; stay IDLE.
- BUSY:
  - div_start_o held 1; operands held stable.
  - On div_ready_i & !flush_i: hi_o ← div_result_i[63:32], lo_o ← div_result_i[31:0]; div_start_o ← 0; go DONE.
- DONE:
  - hi_o/lo_o stable.
  - If stall_i: stay DONE; no new start.
  - Else go IDLE.
  - flush_i in DONE: go IDLE; whilo_o suppressed.
- Flush in BUSY: div_start_o ← 0, div_annul_o ← 1, go ABORT.
- ABORT:
  - Fixed 3 cycles, via a 2-bit counter; covers divider DivByZero→DivEnd→Free.
  - div_annul_o stays 1 during the first cycle only; div_start_o stays 0 throughout.
  - Then go IDLE.
  - A request arriving during ABORT is stalled, not started.
- stallreq_o = (IDLE & req_valid_i & !flush_i) | BUSY | (ABORT & req_valid_i).
- whilo_o = DONE & !flush_i. This holds through stall_i, so EX/MEM captures it exactly when the pipeline advances.
- The signed/unsigned correction is performed by the divider; this block does no arithmetic on results.

## Timing
- Request seen in IDLE at cycle T. div_start_o high from T+1.
- Divider behaviour:
  - DivOn occupies T+2..T+34 (32 iterations + sign fix).
  - DivEnd from T+35.
  - div_ready_i high from T+36.
- Normal division: DONE in T+37. stallreq_o high T..T+36 (37 cycles). whilo_o high in T+37.
- Divisor 0 (no fastpath): DivByZero T+2, DivEnd T+3, ready T+4, DONE T+5, result 0/0.
- div_start_o falls on entry to DONE. The divider returns to Free one cycle later, before any next start (earliest T+38 start for back-to-back requests).
- Reset mid-operation: immediate IDLE, outputs 0. The divider is reset by the same rst.

## Configuration
- DIV_ZERO_FASTPATH_EN defined:
  - In IDLE, a request with req_op2_i == 0 and !flush_i goes directly to DONE with hi_o = lo_o = 0.
  - div_start_o is never raised; stallreq_o is high only in cycle T; DONE at T+1.
- Undefined: divide-by-zero goes through the divider as in Timing (DONE at T+5).

## Test plan
- DIVU 100 / 7: req at T → div_start_o T+1, DONE T+37, lo_o = 14, hi_o = 2, whilo_o one cycle, stallreq_o 37 cycles.
- DIV 0xFFFFFFF9 (-7) / 2: lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE: lo_o = 0xFFFFFFFD, hi_o = 1.
- DIVU 5 / 0:
  - Without macro: DONE T+5, hi_o = lo_o = 0.
  - With DIV_ZERO_FASTPATH_EN: DONE T+1, div_start_o never high.
- Flush at T+10 during BUSY:
  - div_annul_o pulse at T+11, ABORT 3 cycles, no whilo_o.
  - A new DIVU 9/3 issued afterwards gives lo_o = 3, hi_o = 0.
- stall_i high for 3 cycles on entering DONE: whilo_o and hi/lo held 3+1 cycles; div_start_o stays 0; exactly one division started.
- rst asserted at T+20 during BUSY: next cycle all outputs 0, state IDLE; a subsequent request completes normally.
